// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - shared types and sizing helpers for the digit-serial adder
//
// Contents:
//   estado_t   : controller states LIBRE / SUMANDO / ENTREGA
//   pasos()    : number of digit steps for one operation (ANCHO/DIGITO)
//   ancho_paso(): step counter width, $clog2(PASOS) with a minimum of 1
package sumador_pkg;

  typedef enum logic [1:0] {
    LIBRE   = 2'd0,
    SUMANDO = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  function automatic int pasos(input int ancho, input int digito);
    return ancho / digito;
  endfunction

  function automatic int ancho_paso(input int n_pasos);
    return (n_pasos > 1) ? $clog2(n_pasos) : 1;
  endfunction

endpackage

// File: rtl/sumador_secuencial_if.sv
// rtl/sumador_secuencial_if.sv - operand/result handshake bundle of sumador_secuencial
//
// Optional macro: SUMADOR_DESBORDE_EN adds the desborde signal.
// Signals:
//   entValido/entListo           operand handshake
//   entrada1/entrada2/entAcarreo operands and carry-in
//   salValido/salListo           result handshake
//   suma/acarreo                 registered sum and carry-out
//   ocupado                      operation in progress or result pending
//   desborde                     signed overflow (optional)
// Modports: master = operand producer / result consumer, slave = adder.
interface sumador_secuencial_if #(
  parameter int ANCHO = 16
);

  logic             entValido;
  logic             entListo;
  logic [ANCHO-1:0] entrada1;
  logic [ANCHO-1:0] entrada2;
  logic             entAcarreo;
  logic             salValido;
  logic             salListo;
  logic [ANCHO-1:0] suma;
  logic             acarreo;
  logic             ocupado;
`ifdef SUMADOR_DESBORDE_EN
  logic             desborde;

  modport master (
    output entValido, entrada1, entrada2, entAcarreo, salListo,
    input  entListo, salValido, suma, acarreo, ocupado, desborde
  );

  modport slave (
    input  entValido, entrada1, entrada2, entAcarreo, salListo,
    output entListo, salValido, suma, acarreo, ocupado, desborde
  );
`else
  modport master (
    output entValido, entrada1, entrada2, entAcarreo, salListo,
    input  entListo, salValido, suma, acarreo, ocupado
  );

  modport slave (
    input  entValido, entrada1, entrada2, entAcarreo, salListo,
    output entListo, salValido, suma, acarreo, ocupado
  );
`endif

endinterface

// File: rtl/sumador_digito.sv
// rtl/sumador_digito.sv - combinational DIGITO-bit ripple-carry adder slice
//
// Ports:
//   i_a, i_b : DIGITO-bit operand slices
//   i_c      : carry-in
//   o_s      : DIGITO-bit sum
//   o_c      : carry out of the slice MSB
//   o_c_msb  : carry into the slice MSB (overflow detection)
module sumador_digito #(
  parameter int DIGITO = 4
) (
  input  logic [DIGITO-1:0] i_a,
  input  logic [DIGITO-1:0] i_b,
  input  logic              i_c,
  output logic [DIGITO-1:0] o_s,
  output logic              o_c,
  output logic              o_c_msb
);

  logic w_c;

  always_comb begin
    w_c     = i_c;
    o_s     = '0;
    o_c_msb = 1'b0;
    for (int k = 0; k < DIGITO; k++) begin
      if (k == DIGITO - 1) begin
        o_c_msb = w_c;
      end
      o_s[k] = i_a[k] ^ i_b[k] ^ w_c;
      w_c    = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
    end
    o_c = w_c;
  end

endmodule

// File: rtl/sumador_secuencial.sv
// rtl/sumador_secuencial.sv - digit-serial ANCHO-bit adder, DIGITO bits per clock
//
// Optional macro: SUMADOR_DESBORDE_EN enables the signed-overflow flag desborde.
// Ports:
//   reloj    : clock, rising edge
//   reinicio : synchronous active-high reset
//   io_bus   : sumador_secuencial_if.slave (operand/result handshakes, suma,
//              acarreo, ocupado, desborde)
// Parameters: ANCHO operand width, DIGITO bits per step (ANCHO % DIGITO == 0).
module sumador_secuencial
  import sumador_pkg::*;
#(
  parameter int ANCHO  = 16,
  parameter int DIGITO = 4
) (
  input  logic                 reloj,
  input  logic                 reinicio,
  sumador_secuencial_if.slave  io_bus
);

  localparam int PASOS = pasos(ANCHO, DIGITO);
  localparam int PW    = ancho_paso(PASOS);
  localparam logic [PW-1:0] ULTIMO = PW'(PASOS - 1);

  if ((DIGITO < 1) || (ANCHO % DIGITO != 0)) begin : g_param_err
    $error("sumador_secuencial: ANCHO must be a positive multiple of DIGITO");
  end

  estado_t          r_estado;
  estado_t          w_estado_sig;
  logic [ANCHO-1:0] r_a;
  logic [ANCHO-1:0] r_b;
  logic [ANCHO-1:0] r_suma;
  logic             r_carry;
  logic             r_acarreo;
  logic [PW-1:0]    r_paso;

  logic [DIGITO-1:0] w_slice_a;
  logic [DIGITO-1:0] w_slice_b;
  logic [DIGITO-1:0] w_slice_s;
  logic [ANCHO-1:0]  w_suma_sig;
  logic              w_c_out;
  logic              w_c_msb;
  logic              w_acepta;
  logic              w_ultimo;

  assign w_acepta = (r_estado == LIBRE) && io_bus.entValido;
  assign w_ultimo = (r_estado == SUMANDO) && (r_paso == ULTIMO);

  // Handshake flags come straight from the state register.
  assign io_bus.entListo  = (r_estado == LIBRE);
  assign io_bus.salValido = (r_estado == ENTREGA);
  assign io_bus.ocupado   = (r_estado != LIBRE);
  assign io_bus.suma      = r_suma;
  assign io_bus.acarreo   = r_acarreo;

  always_ff @(posedge reloj) begin
    if (reinicio) begin
      r_estado <= LIBRE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      LIBRE:   if (io_bus.entValido) w_estado_sig = SUMANDO;
      SUMANDO: if (r_paso == ULTIMO) w_estado_sig = ENTREGA;
      ENTREGA: if (io_bus.salListo)  w_estado_sig = LIBRE;
      default: w_estado_sig = LIBRE;
    endcase
  end

  // Operands stay put after capture; the step counter picks the slice and
  // the matching destination field of suma.
  always_comb begin
    w_slice_a  = '0;
    w_slice_b  = '0;
    w_suma_sig = r_suma;
    for (int k = 0; k < PASOS; k++) begin
      if (r_paso == PW'(k)) begin
        w_slice_a = r_a[k*DIGITO +: DIGITO];
        w_slice_b = r_b[k*DIGITO +: DIGITO];
        w_suma_sig[k*DIGITO +: DIGITO] = w_slice_s;
      end
    end
  end

  sumador_digito #(
    .DIGITO (DIGITO)
  ) u_digito (
    .i_a     (w_slice_a),
    .i_b     (w_slice_b),
    .i_c     (r_carry),
    .o_s     (w_slice_s),
    .o_c     (w_c_out),
    .o_c_msb (w_c_msb)
  );

  always_ff @(posedge reloj) begin
    if (reinicio) begin
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_paso    <= '0;
      r_suma    <= '0;
      r_acarreo <= 1'b0;
    end else if (w_acepta) begin
      r_a     <= io_bus.entrada1;
      r_b     <= io_bus.entrada2;
      r_carry <= io_bus.entAcarreo;
      r_paso  <= '0;
    end else if (r_estado == SUMANDO) begin
      r_suma  <= w_suma_sig;
      r_carry <= w_c_out;
      r_paso  <= r_paso + PW'(1);
      if (w_ultimo) begin
        r_acarreo <= w_c_out;
      end
    end
  end

`ifdef SUMADOR_DESBORDE_EN
  logic r_desborde;

  // On the last step the slice MSB is the operand MSB, so the two carries
  // around it give the two's-complement overflow.
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      r_desborde <= 1'b0;
    end else if (w_ultimo) begin
      r_desborde <= w_c_msb ^ w_c_out;
    end
  end

  assign io_bus.desborde = r_desborde;
`else
  // The carry into the MSB only feeds the overflow flag.
  logic w_unused;
  assign w_unused = w_c_msb;
`endif

endmodule

// File: tb/tb_sumador_secuencial.sv
// tb/tb_sumador_secuencial.sv - self-checking bench for sumador_secuencial
module tb_sumador_secuencial;

  localparam int ANCHO  = 16;
  localparam int DIGITO = 4;
  localparam int PASOS  = ANCHO / DIGITO;

  logic reloj    = 1'b0;
  logic reinicio = 1'b1;

  always #5 reloj = ~reloj;

  sumador_secuencial_if #(.ANCHO(ANCHO)) bus ();

  sumador_secuencial #(
    .ANCHO  (ANCHO),
    .DIGITO (DIGITO)
  ) dut (
    .reloj    (reloj),
    .reinicio (reinicio),
    .io_bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction-level view (idle / counting down / holding)
  bit               m_busy  = 0;
  bit               m_valid = 0;
  int               m_cnt   = 0;
  int               m_acc   = 0;
  logic [ANCHO:0]   m_pend  = '0;
  bit               m_pend_ovf = 0;
  logic [ANCHO-1:0] m_suma  = '0;
  logic             m_acarreo = 1'b0;
  bit               m_desb  = 0;
  bit               chk_en  = 0;

  always @(posedge reloj) begin
    if (reinicio) begin
      m_busy = 0; m_valid = 0; m_cnt = 0;
      m_suma = '0; m_acarreo = 1'b0; m_desb = 0;
    end else if (!m_busy) begin
      if (bus.entValido) begin
        m_busy = 1;
        m_cnt  = PASOS;
        m_pend = {1'b0, bus.entrada1} + {1'b0, bus.entrada2} + {{ANCHO{1'b0}}, bus.entAcarreo};
        m_pend_ovf = (bus.entrada1[ANCHO-1] == bus.entrada2[ANCHO-1]) &&
                     (m_pend[ANCHO-1] != bus.entrada1[ANCHO-1]);
        m_acc++;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid   = 1;
        m_suma    = m_pend[ANCHO-1:0];
        m_acarreo = m_pend[ANCHO];
        m_desb    = m_pend_ovf;
      end
    end else if (bus.salListo) begin
      m_valid = 0;
      m_busy  = 0;
    end
  end

  // Single compare process, away from the active edge
  always @(negedge reloj) begin
    if (chk_en && !reinicio) begin
      chk("entListo", {31'd0, bus.entListo}, {31'd0, !m_busy});
      chk("salValido", {31'd0, bus.salValido}, {31'd0, m_valid});
      chk("ocupado", {31'd0, bus.ocupado}, {31'd0, m_busy});
      if (m_valid) begin
        chk("suma", {16'd0, bus.suma}, {16'd0, m_suma});
        chk("acarreo", {31'd0, bus.acarreo}, {31'd0, m_acarreo});
`ifdef SUMADOR_DESBORDE_EN
        chk("desborde", {31'd0, bus.desborde}, {31'd0, m_desb});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge reloj);
    #2;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int start;
    int i;
    start = m_acc;
    bus.entrada1   = a;
    bus.entrada2   = b;
    bus.entAcarreo = cin;
    bus.entValido  = 1'b1;
    i = 0;
    while (m_acc == start && i < 50) begin
      tick();
      i++;
    end
    if (m_acc == start) chk("accept_timeout", 32'd0, 32'd1);
    bus.entValido = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge reloj);
      if (bus.salValido === 1'b1) break;
      lat++;
    end
    if (lat >= 50) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_result();
    tick();
    bus.salListo = 1'b1;
    tick();
    bus.salListo = 1'b0;
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                    input logic [15:0] exp_s, input logic exp_c, input logic exp_d);
    int lat;
    send(a, b, cin);
    wait_valid(lat);
    chk("latency", lat, 32'd4);
    chk("suma_lit", {16'd0, bus.suma}, {16'd0, exp_s});
    chk("acarreo_lit", {31'd0, bus.acarreo}, {31'd0, exp_c});
`ifdef SUMADOR_DESBORDE_EN
    chk("desborde_lit", {31'd0, bus.desborde}, {31'd0, exp_d});
`else
    if (exp_d === 1'bx) chk("desborde_arg", 32'd0, 32'd1);
`endif
    release_result();
  endtask

  initial begin
    int lat;
    bus.entValido  = 1'b0;
    bus.entrada1   = '0;
    bus.entrada2   = '0;
    bus.entAcarreo = 1'b0;
    bus.salListo   = 1'b0;

    // Reset held for two cycles
    reinicio = 1'b1;
    tick();
    tick();
    reinicio = 1'b0;
    chk_en = 1;
    @(negedge reloj);
    chk("rst_entListo", {31'd0, bus.entListo}, 32'd1);
    chk("rst_salValido", {31'd0, bus.salValido}, 32'd0);
    chk("rst_ocupado", {31'd0, bus.ocupado}, 32'd0);
    chk("rst_suma", {16'd0, bus.suma}, 32'h0000);
    chk("rst_acarreo", {31'd0, bus.acarreo}, 32'd0);
`ifdef SUMADOR_DESBORDE_EN
    chk("rst_desborde", {31'd0, bus.desborde}, 32'd0);
`endif

    op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);

    // Backpressure: result held, new operands ignored
    send(16'h1234, 16'h1111, 1'b0);
    wait_valid(lat);
    chk("bp_latency", lat, 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.entValido = 1'b1;
      bus.entrada1  = 16'hAAAA;
      bus.entrada2  = 16'h5555;
      @(negedge reloj);
      chk("bp_entListo", {31'd0, bus.entListo}, 32'd0);
      chk("bp_suma", {16'd0, bus.suma}, 32'h2345);
      chk("bp_acarreo", {31'd0, bus.acarreo}, 32'd0);
    end
    tick();
    bus.entValido = 1'b0;
    bus.salListo  = 1'b1;
    tick();
    bus.salListo  = 1'b0;
    op(16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);

    // Reset in the middle of an operation
    send(16'h1234, 16'h4321, 1'b0);
    tick();
    tick();
    reinicio = 1'b1;
    tick();
    reinicio = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge reloj);
      chk("abort_salValido", {31'd0, bus.salValido}, 32'd0);
    end
    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Signed overflow corners
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      tick();
      bus.entValido  = ($urandom_range(0, 2) == 0);
      bus.entrada1   = 16'($urandom);
      bus.entrada2   = 16'($urandom);
      bus.entAcarreo = 1'($urandom_range(0, 1));
      bus.salListo   = 1'($urandom_range(0, 1));
      reinicio       = ($urandom_range(0, 299) == 0);
    end
    tick();
    bus.entValido = 1'b0;
    bus.salListo  = 1'b1;
    reinicio      = 1'b0;
    repeat (PASOS + 4) tick();
    @(negedge reloj);
    chk("final_idle", {31'd0, bus.entListo}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
